// File: rtl/calc_pkg.sv
// Shared calculator definitions: FSM state encoding, opcode width/values and default data width.
// Used by the ALU arbiter, its round-robin grant helper and the ALU itself.
package calc_pkg;

  localparam int OP_W      = 3;
  localparam int DEF_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam logic [OP_W-1:0] ALU_ADD = 3'd0;
  localparam logic [OP_W-1:0] ALU_SUB = 3'd1;
  localparam logic [OP_W-1:0] ALU_AND = 3'd2;
  localparam logic [OP_W-1:0] ALU_OR  = 3'd3;
  localparam logic [OP_W-1:0] ALU_XOR = 3'd4;
  localparam logic [OP_W-1:0] ALU_NOT = 3'd5;
  localparam logic [OP_W-1:0] ALU_SHL = 3'd6;
  localparam logic [OP_W-1:0] ALU_SHR = 3'd7;

  // A lone requester always wins; on contention the pointer decides.
  function automatic logic rr_pick(input logic [1:0] vld, input logic ptr);
    logic gnt;
    case (vld)
      2'b01:   gnt = 1'b0;
      2'b10:   gnt = 1'b1;
      2'b11:   gnt = ptr;
      default: gnt = 1'b0;
    endcase
    return gnt;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant, combinational from valids and pointer; pointer moves to the
// loser on each accepted grant (hs_en), so back-to-back contention alternates.
module rr_arbiter2
  import calc_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_vld,
  input  logic       hs_en,
  output logic       gnt_vld,
  output logic       gnt_id
);

  logic ptr_q;
  logic ptr_d;

  always_comb begin
    gnt_vld = |req_vld;
    gnt_id  = rr_pick(req_vld, ptr_q);
    ptr_d   = ptr_q;
    if (hs_en) begin
      ptr_d = ~gnt_id;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external ALU between two valid/ready requesters; response after ALU_LAT+1 cycles.
// Accepts nothing while an operation is in flight; the response holds until rsp_ready.
module alu_arbiter
  import calc_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int ALU_LAT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [OP_W-1:0]  req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [OP_W-1:0]  req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic [OP_W-1:0]  alu_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_result,
  output logic             rsp_valid,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_data,
  input  logic             rsp_ready,
  output logic             busy
);

  localparam int CNT_W = 3;

  state_e           state_q,    state_d;
  logic [CNT_W-1:0] cnt_q,      cnt_d;
  logic [OP_W-1:0]  alu_op_q,   alu_op_d;
  logic [WIDTH-1:0] alu_a_q,    alu_a_d;
  logic [WIDTH-1:0] alu_b_q,    alu_b_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic             rsp_id_q,   rsp_id_d;
  logic             rsp_vld_q,  rsp_vld_d;
  logic             busy_q,     busy_d;

  logic gnt_vld;
  logic gnt_id;
  logic hs;

  // Readies are gated by rst_n so nothing is offered while reset is held.
  assign hs         = rst_n & (state_q == ST_IDLE) & gnt_vld;
  assign req0_ready = hs & ~gnt_id;
  assign req1_ready = hs & gnt_id;

  rr_arbiter2 u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req_vld ({req1_valid, req0_valid}),
    .hs_en   (hs),
    .gnt_vld (gnt_vld),
    .gnt_id  (gnt_id)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    alu_op_d   = alu_op_q;
    alu_a_d    = alu_a_q;
    alu_b_d    = alu_b_q;
    rsp_data_d = rsp_data_q;
    rsp_id_d   = rsp_id_q;
    rsp_vld_d  = rsp_vld_q;
    case (state_q)
      ST_IDLE: begin
        if (hs) begin
          alu_op_d = gnt_id ? req1_op : req0_op;
          alu_a_d  = gnt_id ? req1_a  : req0_a;
          alu_b_d  = gnt_id ? req1_b  : req0_b;
          rsp_id_d = gnt_id;
          cnt_d    = CNT_W'(ALU_LAT);
          state_d  = ST_EXEC;
        end
      end
      ST_EXEC: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          rsp_data_d = alu_result;
          rsp_vld_d  = 1'b1;
          state_d    = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_vld_d = 1'b0;
          state_d   = ST_IDLE;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        rsp_vld_d = 1'b0;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      alu_op_q   <= '0;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      rsp_data_q <= '0;
      rsp_id_q   <= 1'b0;
      rsp_vld_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      alu_op_q   <= alu_op_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      rsp_data_q <= rsp_data_d;
      rsp_id_q   <= rsp_id_d;
      rsp_vld_q  <= rsp_vld_d;
      busy_q     <= busy_d;
    end
  end

  assign alu_op    = alu_op_q;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_valid = rsp_vld_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: two instances (ALU latency 1 and 3) driven in lockstep, each checked
// every cycle against a transaction-level reference model.
module tb_alu_arbiter;
  import calc_pkg::*;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic         v0, v1, rsp_ready;
  logic [2:0]   op0, op1;
  logic [W-1:0] a0, b0, a1, b1;

  logic         r0 [2];
  logic         r1 [2];
  logic         rv [2];
  logic         rid[2];
  logic         bsy[2];
  logic [2:0]   aop[2];
  logic [W-1:0] aa [2];
  logic [W-1:0] ab [2];
  logic [W-1:0] ares[2];
  logic [W-1:0] rd [2];

  alu_arbiter #(.WIDTH(W), .ALU_LAT(1)) u_lat1 (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(v0), .req0_ready(r0[0]), .req0_op(op0), .req0_a(a0), .req0_b(b0),
    .req1_valid(v1), .req1_ready(r1[0]), .req1_op(op1), .req1_a(a1), .req1_b(b1),
    .alu_op(aop[0]), .alu_a(aa[0]), .alu_b(ab[0]), .alu_result(ares[0]),
    .rsp_valid(rv[0]), .rsp_id(rid[0]), .rsp_data(rd[0]), .rsp_ready(rsp_ready),
    .busy(bsy[0])
  );

  alu_arbiter #(.WIDTH(W), .ALU_LAT(3)) u_lat3 (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(v0), .req0_ready(r0[1]), .req0_op(op0), .req0_a(a0), .req0_b(b0),
    .req1_valid(v1), .req1_ready(r1[1]), .req1_op(op1), .req1_a(a1), .req1_b(b1),
    .alu_op(aop[1]), .alu_a(aa[1]), .alu_b(ab[1]), .alu_result(ares[1]),
    .rsp_valid(rv[1]), .rsp_id(rid[1]), .rsp_data(rd[1]), .rsp_ready(rsp_ready),
    .busy(bsy[1])
  );

  // Bench ALU: add/sub, combinational for latency 1, two extra register stages for latency 3.
  function automatic logic [W-1:0] alu_f(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    return (op == ALU_SUB) ? (a - b) : (a + b);
  endfunction

  logic [W-1:0] p1, p2;
  assign ares[0] = alu_f(aop[0], aa[0], ab[0]);
  always @(posedge clk) begin
    p1 <= alu_f(aop[1], aa[1], ab[1]);
    p2 <= p1;
  end
  assign ares[1] = p2;

  // Reference model: one outstanding transaction per instance, with the cycle its result appears.
  int           lat[2] = '{1, 3};
  bit           bm[2];
  int           done_at[2];
  logic [W-1:0] e_data[2];
  logic         e_id[2];
  logic [2:0]   h_op[2];
  logic [W-1:0] h_a[2];
  logic [W-1:0] h_b[2];
  logic         ptr_m[2];
  logic         gv_m[2];
  logic         g_m[2];
  logic         rv_m[2];
  int           cyc = 0;
  int           n_cmp = 0;
  int           n_err = 0;

  task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s lat%0d cyc%0d: observed %0h expected %0h", tag, lat[k], cyc, obs, exp);
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        bm[k] = 1'b0; ptr_m[k] = 1'b0; e_data[k] = '0; e_id[k] = 1'b0;
        h_op[k] = '0; h_a[k] = '0; h_b[k] = '0;
      end
      gv_m[k] = rst_n && !bm[k] && (v0 || v1);
      g_m[k]  = (v0 && v1) ? ptr_m[k] : v1;
      rv_m[k] = bm[k] && (cyc >= done_at[k]);
      chk("req0_ready", k, 32'(r0[k]),  32'(gv_m[k] && !g_m[k]));
      chk("req1_ready", k, 32'(r1[k]),  32'(gv_m[k] && g_m[k]));
      chk("rsp_valid",  k, 32'(rv[k]),  32'(rv_m[k]));
      chk("busy",       k, 32'(bsy[k]), 32'(bm[k]));
      chk("alu_op",     k, 32'(aop[k]), 32'(h_op[k]));
      chk("alu_a",      k, 32'(aa[k]),  32'(h_a[k]));
      chk("alu_b",      k, 32'(ab[k]),  32'(h_b[k]));
      if (rv_m[k] || !rst_n) begin
        chk("rsp_data", k, 32'(rd[k]),  32'(e_data[k]));
        chk("rsp_id",   k, 32'(rid[k]), 32'(e_id[k]));
      end
    end
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (rst_n) begin
        if (rv_m[k] && rsp_ready) bm[k] = 1'b0;
        if (gv_m[k]) begin
          bm[k]      = 1'b1;
          done_at[k] = cyc + lat[k] + 1;
          h_op[k]    = g_m[k] ? op1 : op0;
          h_a[k]     = g_m[k] ? a1  : a0;
          h_b[k]     = g_m[k] ? b1  : b0;
          e_data[k]  = (h_op[k] == 3'd1) ? (h_a[k] - h_b[k]) : (h_a[k] + h_b[k]);
          e_id[k]    = g_m[k];
          ptr_m[k]   = !g_m[k];
        end
      end
    end
    cyc++;
    #1;
  endtask

  initial begin
    rst_n = 1'b0; v0 = 1'b0; v1 = 1'b0; rsp_ready = 1'b1;
    op0 = '0; op1 = '0; a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    repeat (2) cycle();
    v0 = 1'b1; v1 = 1'b1;
    cycle();
    v0 = 1'b0; v1 = 1'b0; rst_n = 1'b1;
    cycle();

    // Single request from requester 0: 0x12 + 0x34.
    v0 = 1'b1; op0 = 3'd0; a0 = 8'h12; b0 = 8'h34;
    cycle();
    v0 = 1'b0;
    repeat (6) cycle();

    // Continuous contention, then requester 1 alone right after its own grant.
    v0 = 1'b1; op0 = 3'd1; a0 = 8'h50; b0 = 8'h07;
    v1 = 1'b1; op1 = 3'd0; a1 = 8'h21; b1 = 8'h0F;
    repeat (20) cycle();
    v0 = 1'b0;
    repeat (10) cycle();
    v1 = 1'b0;
    repeat (6) cycle();

    // Backpressure: response held for several cycles while requester 1 waits.
    v0 = 1'b1; op0 = 3'd1; a0 = 8'h30; b0 = 8'h45;
    cycle();
    v0 = 1'b0; v1 = 1'b1; op1 = 3'd0; a1 = 8'h11; b1 = 8'h22; rsp_ready = 1'b0;
    repeat (9) cycle();
    rsp_ready = 1'b1;
    repeat (8) cycle();
    v1 = 1'b0;
    repeat (6) cycle();

    // Wrapping add through both latencies.
    v1 = 1'b1; op1 = 3'd0; a1 = 8'hFF; b1 = 8'h02;
    cycle();
    v1 = 1'b0;
    repeat (6) cycle();

    // Reset during EXEC drops the operation and returns the pointer to requester 0.
    v1 = 1'b1; op1 = 3'd1; a1 = 8'h09; b1 = 8'h03;
    cycle();
    v1 = 1'b0;
    cycle();
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1; v0 = 1'b1; v1 = 1'b1; a0 = 8'h44; b0 = 8'h11;
    repeat (12) cycle();
    v0 = 1'b0; v1 = 1'b0;
    repeat (6) cycle();

    // Random traffic, random backpressure and occasional reset pulses.
    repeat (500) begin
      v0 = 1'($urandom_range(0, 1)); v1 = 1'($urandom_range(0, 1));
      op0 = 3'($urandom_range(0, 1)); op1 = 3'($urandom_range(0, 1));
      a0 = 8'($urandom); b0 = 8'($urandom); a1 = 8'($urandom); b1 = 8'($urandom);
      rsp_ready = ($urandom_range(0, 3) != 0);
      rst_n = ($urandom_range(0, 63) != 0);
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares the single ALU between two requesters, each using a valid/ready handshake.
- Requester 0 is the front-panel calculator FSM; requester 1 is a self-test/demo sequencer.
- Arbitrates round-robin, latches the operands, holds them on the ALU for a fixed latency, then returns the result on a response channel with backpressure.
- The ALU itself stays outside this block.

Parameters:
- WIDTH, 8: operand and result width in bits.
- ALU_LAT, 1: cycles from stable ALU inputs to a valid alu_result. Legal range is 1..4.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req0_valid  in  1  requester 0 has an operation pending.
- req0_ready  out  1  requester 0 operation accepted this cycle.
- req0_op  in  3  requester 0 ALU opcode.
- req0_a  in  WIDTH  requester 0 operand one.
- req0_b  in  WIDTH  requester 0 operand two.
- req1_valid, req1_ready, req1_op, req1_a, req1_b: same as requester 0, for requester 1.
- alu_op  out  3  opcode driven to the ALU.
- alu_a  out  WIDTH  operand one driven to the ALU.
- alu_b  out  WIDTH  operand two driven to the ALU.
- alu_result  in  WIDTH  ALU output.
- rsp_valid  out  1  response available.
- rsp_id  out  1  requester that owns the response.
- rsp_data  out  WIDTH  captured ALU result.
- rsp_ready  in  1  response consumer accepts.
- busy  out  1  high when state is not IDLE.

Behaviour:
- Reset (asynchronous, rst_n low):
  - state goes to IDLE; round-robin pointer goes to 0.
  - alu_op, alu_a, alu_b, rsp_data, rsp_id, rsp_valid, busy and both readies are all 0.
  - The latency counter is 0.
- States: IDLE, EXEC, RESP.
- IDLE:
  - Grant logic:
    - Only req0 valid: grant 0.
    - Only req1 valid: grant 1.
    - Both valid: grant the requester named by the pointer.
  - reqN_ready is asserted combinationally, only in IDLE, only to the granted requester. Never to both.
  - On handshake (valid & ready), in the same edge:
    - Capture op, a and b into alu_op, alu_a and alu_b.
    - Capture the grant into rsp_id.
    - Set pointer to the other requester (~grant).
    - Load the counter with ALU_LAT.
    - Go to EXEC.
  - No valid: stay in IDLE; ALU outputs hold their last values.
- EXEC:
  - ALU outputs are stable for the whole state.
  - The counter decrements each cycle.
  - In the cycle where the counter equals 1: capture alu_result into rsp_data, set rsp_valid, go to RESP.
  - EXEC therefore lasts exactly ALU_LAT cycles.
- RESP:
  - rsp_valid, rsp_data and rsp_id are held stable until rsp_ready is high.
  - On rsp_ready: clear rsp_valid and go to IDLE.
  - rsp_ready high in the first RESP cycle completes the response in that cycle.
- Latency: handshake at edge t gives rsp_valid from cycle t+ALU_LAT+1.
- Throughput: at best one operation per ALU_LAT+2 cycles. No new request is accepted while in EXEC or RESP.
- Requester obligation: hold valid and payload stable until ready. Payload is sampled only on handshake.
- Opcodes pass through unmodified; unknown opcodes are not checked.
- Results are not widened. Wrap and overflow are the ALU's responsibility.
- Reset mid-operation: the in-flight operation is dropped, no response is produced, and the pointer returns to 0.
- req deasserted after handshake: no effect.
- rsp_ready high outside RESP: ignored.

Decomposition:
- Shared package calc_pkg holds:
  - the state enum (IDLE, EXEC, RESP);
  - OP_W = 3;
  - the default WIDTH;
  - the ALU opcode constants.
- The FSM and the ALU use the same calc_pkg constants.
- One sub-module, rr_arbiter2: combinational two-way grant from valids and pointer, plus the pointer register, updated on a handshake-enable input.

Test Plan:
- The bench ALU model is combinational with op 0 = a+b, op 1 = a-b. It is delayed ALU_LAT-1 registers for tests with ALU_LAT > 1.
- Reset: rst_n low mid-simulation -> all outputs 0, busy 0, req0_ready and req1_ready 0.
- Single request:
  - Stimulus: req0 op=0, a=8'h12, b=8'h34 at edge t, rsp_ready=1, ALU_LAT=1.
  - Required: req0_ready high in cycle t; alu_a=8'h12, alu_b=8'h34 from t+1; rsp_valid at t+2 with rsp_data=8'h46, rsp_id=0; busy high t+1..t+2.
- Contention:
  - Stimulus: both valid continuously, rsp_ready=1.
  - Required: grants 0,1,0,1; rsp_id alternates.
  - Check: req1 alone after a req1 grant is still granted.
- Backpressure:
  - Stimulus: rsp_ready low for 5 cycles during RESP, req1 valid.
  - Required: rsp_valid, rsp_data and rsp_id stable; req1_ready stays 0.
  - Required after release: req1 accepted on the next IDLE cycle.
- Latency and wrap:
  - Stimulus: ALU_LAT=3, req1 op=0, a=8'hFF, b=8'h02.
  - Required: EXEC lasts 3 cycles; rsp_valid 4 cycles after the handshake; rsp_data=8'h01.
- Reset in EXEC:
  - Stimulus: rst_n pulsed low during EXEC, then both requesters valid.
  - Required: no response for the dropped operation; req0 granted first.
